// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Round-robin arbiter and sequencer that shares the single DataMemory port
//   between the CPU load/store unit (port A) and the DMA/fill engine (port B).
//   A granted write takes one ISSUE cycle. A granted read takes one ISSUE
//   cycle plus READ_LATENCY WAIT cycles, and then returns readData to the
//   winner with a one-cycle Rvalid pulse.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   aReq/aWe/aAddr/aWdata      port A request (held until aGnt)
//   aGnt, aRvalid, aRdata      port A grant pulse, read-valid pulse, read data
//   bReq/bWe/bAddr/bWdata      port B request (held until bGnt)
//   bGnt, bRvalid, bRdata      port B grant pulse, read-valid pulse, read data
//   memWrite, memRead          DataMemory write and read enables
//   address, writeData         DataMemory address and write data
//   readData                   DataMemory read data
//   busy                       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 48,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 1      // legal range 1..7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aReq,
    input  logic              aWe,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [DATA_W-1:0] aWdata,
    output logic              aGnt,
    output logic              aRvalid,
    output logic [DATA_W-1:0] aRdata,
    input  logic              bReq,
    input  logic              bWe,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [DATA_W-1:0] bWdata,
    output logic              bGnt,
    output logic              bRvalid,
    output logic [DATA_W-1:0] bRdata,
    output logic              memWrite,
    output logic              memRead,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

    state_t            r_state;
    logic              r_ptr;       // 0: A has priority on a tie, 1: B
    logic              r_sel;       // winner of the current transaction (1 = B)
    logic              r_we;
    logic [2:0]        r_cnt;
    logic              r_aGnt, r_bGnt, r_aRvalid, r_bRvalid;
    logic              r_memWrite, r_memRead;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_writeData, r_aRdata, r_bRdata;

    logic              w_bWins;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // B wins when it is the only requester, or on a tie when it holds priority.
    assign w_bWins = bReq & (~aReq | r_ptr);
    assign w_we    = w_bWins ? bWe    : aWe;
    assign w_addr  = w_bWins ? bAddr  : aAddr;
    assign w_wdata = w_bWins ? bWdata : aWdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_sel       <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= 3'd0;
            r_aGnt      <= 1'b0;
            r_bGnt      <= 1'b0;
            r_aRvalid   <= 1'b0;
            r_bRvalid   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memRead   <= 1'b0;
            r_address   <= '0;
            r_writeData <= '0;
            r_aRdata    <= '0;
            r_bRdata    <= '0;
        end else begin
            // Grant, write-enable and read-valid are single-cycle pulses.
            r_aGnt     <= 1'b0;
            r_bGnt     <= 1'b0;
            r_aRvalid  <= 1'b0;
            r_bRvalid  <= 1'b0;
            r_memWrite <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (aReq || bReq) begin
                        r_sel       <= w_bWins;
                        r_we        <= w_we;
                        r_address   <= w_addr;
                        r_writeData <= w_wdata;
                        r_ptr       <= ~w_bWins;   // loser gets priority next time
                        r_aGnt      <= ~w_bWins;
                        r_bGnt      <= w_bWins;
                        r_memWrite  <= w_we;
                        r_memRead   <= ~w_we;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter at zero marks the cycle readData is valid.
                    if (r_cnt == 3'd0) begin
                        if (r_sel) begin
                            r_bRdata  <= readData;
                            r_bRvalid <= 1'b1;
                        end else begin
                            r_aRdata  <= readData;
                            r_aRvalid <= 1'b1;
                        end
                        r_memRead <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign aGnt      = r_aGnt;
    assign bGnt      = r_bGnt;
    assign aRvalid   = r_aRvalid;
    assign bRvalid   = r_bRvalid;
    assign aRdata    = r_aRdata;
    assign bRdata    = r_bRdata;
    assign memWrite  = r_memWrite;
    assign memRead   = r_memRead;
    assign address   = r_address;
    assign writeData = r_writeData;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Two arbiter instances (READ_LATENCY 1 and 3), each with its own memory
//   whose readData is only correct in the cycle the arbiter must capture it.
//   Directed vector table, multi-cycle corner sequences, then random traffic
//   checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        aReq[2], aWe[2], bReq[2], bWe[2];
    logic [47:0] aAddr[2], bAddr[2], address[2];
    logic [63:0] aWdata[2], bWdata[2], aRdata[2], bRdata[2], writeData[2], readData[2];
    logic        aGnt[2], bGnt[2], aRvalid[2], bRvalid[2], memWrite[2], memRead[2], busy[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RL = (g == 0) ? 1 : 3;
        logic [63:0] mem [128];
        int          rdcnt;

        dmem_arbiter #(.ADDR_W(48), .DATA_W(64), .READ_LATENCY(RL)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .aReq(aReq[g]), .aWe(aWe[g]), .aAddr(aAddr[g]), .aWdata(aWdata[g]),
            .aGnt(aGnt[g]), .aRvalid(aRvalid[g]), .aRdata(aRdata[g]),
            .bReq(bReq[g]), .bWe(bWe[g]), .bAddr(bAddr[g]), .bWdata(bWdata[g]),
            .bGnt(bGnt[g]), .bRvalid(bRvalid[g]), .bRdata(bRdata[g]),
            .memWrite(memWrite[g]), .memRead(memRead[g]), .address(address[g]),
            .writeData(writeData[g]), .readData(readData[g]), .busy(busy[g])
        );

        // Memory: rdcnt = memRead cycles already elapsed; data is valid only
        // in memRead cycle RL+1, garbage otherwise.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdcnt <= 0;
                for (int i = 0; i < 128; i++) mem[i] <= '0;
            end else begin
                rdcnt <= memRead[g] ? rdcnt + 1 : 0;
                if (memWrite[g]) mem[address[g][6:0]] <= writeData[g];
            end
        end
        assign readData[g] = (rdcnt == RL) ? mem[address[g][6:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        for (int g = 0; g < 2; g++) begin
            aReq[g] = 0; aWe[g] = 0; aAddr[g] = '0; aWdata[g] = '0;
            bReq[g] = 0; bWe[g] = 0; bAddr[g] = '0; bWdata[g] = '0;
        end
    endtask

    task automatic do_reset();
        clr_inputs();
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        step();
    endtask

    task automatic chk_zero(input int g, input string nm);
        chkb({nm, ".aGnt"}, aGnt[g], 0);       chkb({nm, ".bGnt"}, bGnt[g], 0);
        chkb({nm, ".aRvalid"}, aRvalid[g], 0); chkb({nm, ".bRvalid"}, bRvalid[g], 0);
        chkb({nm, ".memWrite"}, memWrite[g], 0); chkb({nm, ".memRead"}, memRead[g], 0);
        chkb({nm, ".busy"}, busy[g], 0);
        chk({nm, ".aRdata"}, aRdata[g], 0);    chk({nm, ".bRdata"}, bRdata[g], 0);
        chk({nm, ".address"}, 64'(address[g]), 0); chk({nm, ".writeData"}, writeData[g], 0);
    endtask

    // Single read on one port with bounded waits.
    task automatic rd(input int g, input bit p, input logic [47:0] a, input string nm,
                      output logic [63:0] d);
        int k;
        if (p) begin bReq[g] = 1; bWe[g] = 0; bAddr[g] = a; end
        else   begin aReq[g] = 1; aWe[g] = 0; aAddr[g] = a; end
        k = 0;
        do begin step(); k++; end while (!(p ? bGnt[g] : aGnt[g]) && k < 30);
        chkb({nm, ".gnt"}, p ? bGnt[g] : aGnt[g], 1);
        if (p) bReq[g] = 0; else aReq[g] = 0;
        k = 0;
        do begin step(); k++; end while (!(p ? bRvalid[g] : aRvalid[g]) && k < 30);
        chkb({nm, ".rvalid"}, p ? bRvalid[g] : aRvalid[g], 1);
        d = p ? bRdata[g] : aRdata[g];
    endtask

    task automatic drain(input int g);
        int k;
        k = 0;
        while (busy[g] && k < 30) begin step(); k++; end
        step();
    endtask

    // Directed vectors on instance 0: inputs held for one cycle, expected
    // outputs in the cycle after the sampling edge.
    typedef struct {
        logic        aReq, aWe; logic [47:0] aAddr; logic [63:0] aWdata;
        logic        bReq, bWe; logic [47:0] bAddr; logic [63:0] bWdata;
        logic        eAG, eBG, eMW, eMR, eBusy, eARv, eBRv;
        logic [63:0] eARd; logic [47:0] eAddr;
    } vec_t;

    function automatic vec_t mk(input int aR, aW, aA, aD, bR, bW, bA, bD,
                                input int eAG, eBG, eMW, eMR, eB, eARv, eBRv, eARd, eAd);
        vec_t v;
        v.aReq = aR[0]; v.aWe = aW[0]; v.aAddr = 48'(aA); v.aWdata = 64'(aD);
        v.bReq = bR[0]; v.bWe = bW[0]; v.bAddr = 48'(bA); v.bWdata = 64'(bD);
        v.eAG = eAG[0]; v.eBG = eBG[0]; v.eMW = eMW[0]; v.eMR = eMR[0];
        v.eBusy = eB[0]; v.eARv = eARv[0]; v.eBRv = eBRv[0];
        v.eARd = 64'(eARd); v.eAddr = 48'(eAd);
        return v;
    endfunction

    // Reference model state (per instance): one transaction with an age.
    int          age[2];
    bit          tp[2], tw[2], ptr[2], rvp[2], rvport[2];
    bit          gp[2][2];
    logic [47:0] ta[2];
    logic [63:0] td[2];
    logic [63:0] erd[2][2];
    logic [63:0] rmem[2][128];

    task automatic newreq(input int g, input int p);
        logic        we;
        logic [47:0] a;
        logic [63:0] d;
        we = 1'($urandom % 2);
        a  = 48'($urandom_range(0, 15));
        d  = {$urandom, $urandom};
        if (p == 0) begin aReq[g] = 1; aWe[g] = we; aAddr[g] = a; aWdata[g] = d; end
        else        begin bReq[g] = 1; bWe[g] = we; bAddr[g] = a; bWdata[g] = d; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[11];
        logic [63:0] d;
        int          k, n, ia, ib;
        string       nm;

        clr_inputs();
        #1;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        #10;
        @(negedge clk); rst_n = 1;
        step();

        // ---------------- directed table (instance 0, latency 1) ----------
        tbl[0]  = mk(1,1,5,1,     0,0,0,0,      1,0,1,0,1,0,0, 0, 5);
        tbl[1]  = mk(0,0,0,0,     0,0,0,0,      0,0,0,0,0,0,0, 0, 0);
        tbl[2]  = mk(1,0,5,0,     0,0,0,0,      1,0,0,1,1,0,0, 0, 5);
        tbl[3]  = mk(0,0,0,0,     0,0,0,0,      0,0,0,1,1,0,0, 0, 5);
        tbl[4]  = mk(0,0,0,0,     0,0,0,0,      0,0,0,0,0,1,0, 1, 0);
        tbl[5]  = mk(0,0,0,0,     1,1,10,'h77,  0,1,1,0,1,0,0, 1, 10);
        tbl[6]  = mk(1,1,20,2,    1,1,21,3,     0,0,0,0,0,0,0, 1, 0);
        tbl[7]  = mk(1,1,20,2,    1,1,21,3,     1,0,1,0,1,0,0, 1, 20);
        tbl[8]  = mk(0,0,0,0,     1,1,21,3,     0,0,0,0,0,0,0, 1, 0);
        tbl[9]  = mk(0,0,0,0,     1,1,21,3,     0,1,1,0,1,0,0, 1, 21);
        tbl[10] = mk(0,0,0,0,     0,0,0,0,      0,0,0,0,0,0,0, 1, 0);
        for (int r = 0; r < 11; r++) begin
            aReq[0] = tbl[r].aReq; aWe[0] = tbl[r].aWe; aAddr[0] = tbl[r].aAddr; aWdata[0] = tbl[r].aWdata;
            bReq[0] = tbl[r].bReq; bWe[0] = tbl[r].bWe; bAddr[0] = tbl[r].bAddr; bWdata[0] = tbl[r].bWdata;
            step();
            nm = $sformatf("vec%0d", r);
            chkb({nm, ".aGnt"}, aGnt[0], tbl[r].eAG);
            chkb({nm, ".bGnt"}, bGnt[0], tbl[r].eBG);
            chkb({nm, ".memWrite"}, memWrite[0], tbl[r].eMW);
            chkb({nm, ".memRead"}, memRead[0], tbl[r].eMR);
            chkb({nm, ".busy"}, busy[0], tbl[r].eBusy);
            chkb({nm, ".aRvalid"}, aRvalid[0], tbl[r].eARv);
            chkb({nm, ".bRvalid"}, bRvalid[0], tbl[r].eBRv);
            chk({nm, ".aRdata"}, aRdata[0], tbl[r].eARd);
            if (tbl[r].eBusy) chk({nm, ".address"}, 64'(address[0]), 64'(tbl[r].eAddr));
            if (tbl[r].eMW) chk({nm, ".writeData"}, writeData[0], r == 0 ? 64'd1 : 64'(tbl[r].eAG ? tbl[r].aWdata : tbl[r].bWdata));
        end
        clr_inputs();

        // ---------------- latency 3: B write then read at addr 10 ---------
        bReq[1] = 1; bWe[1] = 1; bAddr[1] = 10; bWdata[1] = 64'hABCD_1234_5678_9ABC;
        step();
        chkb("rl3.wr_gnt", bGnt[1], 1);
        bReq[1] = 0;
        step();
        bReq[1] = 1; bWe[1] = 0; bAddr[1] = 10;
        step();
        chkb("rl3.rd_gnt", bGnt[1], 1);
        bReq[1] = 0;
        n = 0;
        while (memRead[1] && n < 20) begin n++; step(); end
        chk("rl3.memRead_cycles", 64'(n), 64'd4);
        chkb("rl3.bRvalid", bRvalid[1], 1);
        chk("rl3.bRdata", bRdata[1], 64'hABCD_1234_5678_9ABC);
        chkb("rl3.aRvalid", aRvalid[1], 0);
        step();
        chkb("rl3.bRvalid_pulse", bRvalid[1], 0);

        // ---------------- reset in the middle of WAIT ---------------------
        aReq[1] = 1; aWe[1] = 0; aAddr[1] = 10;
        k = 0;
        do begin step(); k++; end while (!aGnt[1] && k < 30);
        chkb("rst.gnt", aGnt[1], 1);
        aReq[1] = 0;
        step();
        chkb("rst.in_wait", memRead[1], 1);
        #2 rst_n = 0;
        #1 chk_zero(1, "rst.async");
        @(negedge clk); rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            chkb($sformatf("rst.no_aRvalid%0d", c), aRvalid[1], 0);
            chkb($sformatf("rst.no_busy%0d", c), busy[1], 0);
        end
        aReq[1] = 1; aWe[1] = 1; aAddr[1] = 1;
        bReq[1] = 1; bWe[1] = 1; bAddr[1] = 2;
        step();
        chkb("rst.ptr_aGnt", aGnt[1], 1);
        chkb("rst.ptr_bGnt", bGnt[1], 0);
        clr_inputs();
        drain(1);

        // ---------------- B raised in the aGnt cycle -----------------------
        for (int g = 0; g < 2; g++) begin
            for (int w = 1; w >= 0; w--) begin
                aReq[g] = 1; aWe[g] = w[0]; aAddr[g] = 3; aWdata[g] = 7;
                k = 0;
                do begin step(); k++; end while (!aGnt[g] && k < 30);
                chkb($sformatf("spc.g%0d.w%0d.aGnt", g, w), aGnt[g], 1);
                aReq[g] = 0;
                bReq[g] = 1; bWe[g] = 0; bAddr[g] = 3;
                k = 0;
                do begin step(); k++; end while (!bGnt[g] && k < 30);
                chk($sformatf("spc.g%0d.w%0d.spacing", g, w), 64'(k),
                    64'(w ? 2 : ((g == 0) ? 1 : 3) + 2));
                bReq[g] = 0;
                drain(g);
            end
        end

        // ---------------- round robin: 16 writes, then read back ----------
        do_reset();
        ia = 0; ib = 1; n = 0;
        aReq[0] = 1; aWe[0] = 1; aAddr[0] = 0; aWdata[0] = 1;
        bReq[0] = 1; bWe[0] = 1; bAddr[0] = 5; bWdata[0] = 2;
        k = 0;
        while (n < 16 && k < 100) begin
            step(); k++;
            if (aGnt[0] && bGnt[0]) chkb("rr.both_gnt", 1'b1, 1'b0);
            if (aGnt[0]) begin
                chk("rr.order_A", 64'(n % 2), 0);
                n++; ia += 2;
                if (ia < 16) begin aAddr[0] = 48'(ia * 5); aWdata[0] = 64'(ia + 1); end
                else aReq[0] = 0;
            end
            if (bGnt[0]) begin
                chk("rr.order_B", 64'(n % 2), 1);
                n++; ib += 2;
                if (ib < 16) begin bAddr[0] = 48'(ib * 5); bWdata[0] = 64'(ib + 1); end
                else bReq[0] = 0;
            end
        end
        chk("rr.count", 64'(n), 16);
        clr_inputs();
        drain(0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                nm = $sformatf("rb.p%0d.i%0d", p, i);
                rd(0, p[0], 48'(i * 5), nm, d);
                chk({nm, ".data"}, d, 64'(i + 1));
            end
        end

        // ---------------- random traffic vs reference model ----------------
        do_reset();
        for (int g = 0; g < 2; g++) begin
            age[g] = -1; ptr[g] = 0; rvp[g] = 0; rvport[g] = 0;
            gp[g][0] = 0; gp[g][1] = 0; erd[g][0] = '0; erd[g][1] = '0;
            tp[g] = 0; tw[g] = 0; ta[g] = '0; td[g] = '0;
            for (int i = 0; i < 128; i++) rmem[g][i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            step();
            for (int g = 0; g < 2; g++) begin
                nm = $sformatf("rnd.c%0d.g%0d", c, g);
                chkb({nm, ".busy"}, busy[g], age[g] >= 0);
                chkb({nm, ".aGnt"}, aGnt[g], age[g] == 0 && !tp[g]);
                chkb({nm, ".bGnt"}, bGnt[g], age[g] == 0 && tp[g]);
                chkb({nm, ".memWrite"}, memWrite[g], age[g] == 0 && tw[g]);
                chkb({nm, ".memRead"}, memRead[g], age[g] >= 0 && !tw[g]);
                chkb({nm, ".aRvalid"}, aRvalid[g], rvp[g] && !rvport[g]);
                chkb({nm, ".bRvalid"}, bRvalid[g], rvp[g] && rvport[g]);
                chk({nm, ".aRdata"}, aRdata[g], erd[g][0]);
                chk({nm, ".bRdata"}, bRdata[g], erd[g][1]);
                if (age[g] >= 0) begin
                    chk({nm, ".address"}, 64'(address[g]), 64'(ta[g]));
                    chk({nm, ".writeData"}, writeData[g], td[g]);
                end

                // Requesters: hold through the grant cycle, move on after it,
                // occasionally give up before being granted.
                if (gp[g][0]) begin if ($urandom % 2 == 0) newreq(g, 0); else aReq[g] = 0; end
                else if (!aReq[g]) begin if ($urandom % 3 == 0) newreq(g, 0); end
                else if (!aGnt[g] && $urandom % 12 == 0) aReq[g] = 0;
                gp[g][0] = aGnt[g];
                if (gp[g][1]) begin if ($urandom % 2 == 0) newreq(g, 1); else bReq[g] = 0; end
                else if (!bReq[g]) begin if ($urandom % 3 == 0) newreq(g, 1); end
                else if (!bGnt[g] && $urandom % 12 == 0) bReq[g] = 0;
                gp[g][1] = bGnt[g];

                // Model: advance one cycle using the inputs now presented.
                rvp[g] = 0;
                if (age[g] < 0) begin
                    if (aReq[g] || bReq[g]) begin
                        tp[g]  = (aReq[g] && bReq[g]) ? ptr[g] : bReq[g];
                        ptr[g] = !tp[g];
                        tw[g]  = tp[g] ? bWe[g]   : aWe[g];
                        ta[g]  = tp[g] ? bAddr[g] : aAddr[g];
                        td[g]  = tp[g] ? bWdata[g] : aWdata[g];
                        age[g] = 0;
                        if (tw[g]) rmem[g][ta[g][6:0]] = td[g];
                    end
                end else begin
                    age[g]++;
                    if (age[g] == (tw[g] ? 1 : ((g == 0) ? 1 : 3) + 1)) begin
                        age[g] = -1;
                        if (!tw[g]) begin
                            rvp[g] = 1; rvport[g] = tp[g];
                            erd[g][tp[g]] = rmem[g][ta[g][6:0]];
                        end
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
